// File: rtl/epl_correlator.sv
// Early/prompt/late correlator with integrate-and-dump readout registers.
// Optional EPL_SAT_EN: accumulators saturate instead of wrapping.

module epl_acc_lane #(
  parameter int SW = 3,
  parameter int AW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 sample_enable,
  input  logic                 chip,
  input  logic signed [SW-1:0] sample,
  input  logic                 dump_enable,
  output logic signed [AW-1:0] dump_val
);
  logic signed [AW-1:0] acc, s_ext, term, upd, nxt;

  // Widen before negating so the most negative sample negates exactly.
  assign s_ext = {{(AW-SW){sample[SW-1]}}, sample};
  assign term  = chip ? s_ext : -s_ext;

`ifdef EPL_SAT_EN
  logic signed [AW:0] sum;
  assign sum = {acc[AW-1], acc} + {term[AW-1], term};
  always_comb begin
    upd = sum[AW-1:0];
    if (sum[AW] != sum[AW-1])
      upd = sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
  end
`else
  assign upd = acc + term;
`endif

  assign nxt = sample_enable ? upd : acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      dump_val <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (dump_enable) begin
      dump_val <= nxt;
      acc      <= '0;
    end else begin
      acc <= nxt;
    end
  end
endmodule

module epl_correlator #(
  parameter int SW = 3,
  parameter int AW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_enable,
  input  logic signed [SW-1:0] i_sample,
  input  logic signed [SW-1:0] q_sample,
  input  logic                 early,
  input  logic                 prompt,
  input  logic                 late,
  input  logic                 dump_enable,
  input  logic                 prn_key_enable,
  input  logic                 rd_strobe,
  output logic signed [AW-1:0] i_early,
  output logic signed [AW-1:0] q_early,
  output logic signed [AW-1:0] i_prompt,
  output logic signed [AW-1:0] q_prompt,
  output logic signed [AW-1:0] i_late,
  output logic signed [AW-1:0] q_late,
  output logic [15:0]          n_samples,
  output logic                 acc_valid,
  output logic                 overrun
);
  localparam int NUM_LANES = 6;

  logic [1:0][SW-1:0]           smp;
  logic [2:0]                   chips;
  logic [NUM_LANES-1:0][AW-1:0] dv;
  logic [15:0]                  cnt;

  assign smp   = {q_sample, i_sample};
  assign chips = {late, prompt, early};

  // Lane k: component k/3 (0=I, 1=Q), chip k%3 (0=early, 1=prompt, 2=late).
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    epl_acc_lane #(.SW(SW), .AW(AW)) u_lane (
      .clk          (clk),
      .rst          (rst),
      .clr          (prn_key_enable),
      .sample_enable(sample_enable),
      .chip         (chips[k % 3]),
      .sample       (smp[k / 3]),
      .dump_enable  (dump_enable),
      .dump_val     (dv[k])
    );
  end

  assign i_early  = dv[0];
  assign i_prompt = dv[1];
  assign i_late   = dv[2];
  assign q_early  = dv[3];
  assign q_prompt = dv[4];
  assign q_late   = dv[5];

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      n_samples <= '0;
      acc_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (prn_key_enable) begin
      cnt       <= '0;
      acc_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (dump_enable) begin
      n_samples <= cnt + 16'(sample_enable);
      cnt       <= '0;
      acc_valid <= 1'b1;
      if (acc_valid && !rd_strobe) overrun <= 1'b1;
    end else begin
      if (sample_enable) cnt <= cnt + 16'd1;
      if (rd_strobe) acc_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_epl_correlator.sv
// Bench for epl_correlator: directed plan steps plus randomized traffic vs. an integer model.
module tb_epl_correlator;
  logic clk = 1'b0;
  logic rst = 1'b0, en = 1'b0, dmp = 1'b0, prn = 1'b0, rd = 1'b0;
  logic e = 1'b1, p = 1'b1, l = 1'b1;
  logic signed [2:0] is = '0, qs = '0;

  logic signed [15:0] a_ie, a_qe, a_ip, a_qp, a_il, a_ql;
  logic signed [7:0]  b_ie, b_qe, b_ip, b_qp, b_il, b_ql;
  logic [15:0] a_n, b_n;
  logic a_v, b_v, a_o, b_o;

  int checks = 0, errors = 0;

  longint m16[6], m8[6], d16[6], d8[6];
  int m_cnt = 0, m_n = 0;
  bit m_v = 0, m_o = 0;

  always #5 clk = ~clk;

  epl_correlator #(.SW(3), .AW(16)) u_dut (
    .clk(clk), .rst(rst), .sample_enable(en), .i_sample(is), .q_sample(qs),
    .early(e), .prompt(p), .late(l), .dump_enable(dmp), .prn_key_enable(prn),
    .rd_strobe(rd), .i_early(a_ie), .q_early(a_qe), .i_prompt(a_ip),
    .q_prompt(a_qp), .i_late(a_il), .q_late(a_ql), .n_samples(a_n),
    .acc_valid(a_v), .overrun(a_o));

  epl_correlator #(.SW(3), .AW(8)) u_dut8 (
    .clk(clk), .rst(rst), .sample_enable(en), .i_sample(is), .q_sample(qs),
    .early(e), .prompt(p), .late(l), .dump_enable(dmp), .prn_key_enable(prn),
    .rd_strobe(rd), .i_early(b_ie), .q_early(b_qe), .i_prompt(b_ip),
    .q_prompt(b_qp), .i_late(b_il), .q_late(b_ql), .n_samples(b_n),
    .acc_valid(b_v), .overrun(b_o));

  function automatic longint fold(longint v, int aw);
    longint half = longint'(1) << (aw - 1);
    longint full = longint'(1) << aw;
`ifdef EPL_SAT_EN
    if (v > half - 1) return half - 1;
    if (v < -half) return -half;
    return v;
`else
    longint r = (v + half) % full;
    if (r < 0) r += full;
    return r - half;
`endif
  endfunction

  // Lane k: k/3 selects I or Q sample, k%3 selects early/prompt/late chip.
  function automatic longint term(int k);
    int s = (k >= 3) ? int'(qs) : int'(is);
    logic c = (k % 3 == 0) ? e : (k % 3 == 1) ? p : l;
    return c ? s : -s;
  endfunction

  task automatic model_step();
    if (rst) begin
      foreach (m16[k]) begin m16[k] = 0; m8[k] = 0; d16[k] = 0; d8[k] = 0; end
      m_cnt = 0; m_n = 0; m_v = 0; m_o = 0;
    end else if (prn) begin
      foreach (m16[k]) begin m16[k] = 0; m8[k] = 0; end
      m_cnt = 0; m_v = 0; m_o = 0;
    end else begin
      if (en) begin
        foreach (m16[k]) begin
          m16[k] = fold(m16[k] + term(k), 16);
          m8[k]  = fold(m8[k] + term(k), 8);
        end
        m_cnt = (m_cnt + 1) % 65536;
      end
      if (dmp) begin
        if (m_v && !rd) m_o = 1;
        foreach (m16[k]) begin d16[k] = m16[k]; d8[k] = m8[k]; m16[k] = 0; m8[k] = 0; end
        m_n = m_cnt; m_cnt = 0; m_v = 1;
      end else if (rd) m_v = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk(string tag, longint obs, longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("ie16", a_ie, d16[0]); chk("ip16", a_ip, d16[1]); chk("il16", a_il, d16[2]);
    chk("qe16", a_qe, d16[3]); chk("qp16", a_qp, d16[4]); chk("ql16", a_ql, d16[5]);
    chk("ie8", b_ie, d8[0]); chk("ip8", b_ip, d8[1]); chk("il8", b_il, d8[2]);
    chk("qe8", b_qe, d8[3]); chk("qp8", b_qp, d8[4]); chk("ql8", b_ql, d8[5]);
    chk("n16", a_n, m_n); chk("n8", b_n, m_n);
    chk("valid16", a_v, m_v); chk("valid8", b_v, m_v);
    chk("ovr16", a_o, m_o); chk("ovr8", b_o, m_o);
  endtask

  task automatic samples(int n, int iv, int qv);
    en = 1; is = 3'(iv); qs = 3'(qv);
    repeat (n) tick();
    en = 0;
  endtask

  task automatic dump_cycle(bit with_sample, bit with_rd);
    dmp = 1; en = with_sample; rd = with_rd;
    tick();
    dmp = 0; en = 0; rd = 0;
  endtask

  task automatic read_cycle();
    rd = 1; tick(); rd = 0;
  endtask

  initial begin
    rst = 1; tick(); rst = 0;
    check_all();
    chk("rst_ie", a_ie, 0); chk("rst_valid", a_v, 0);

    // 1000 all-ones-chip samples.
    e = 1; p = 1; l = 1;
    samples(1000, 3, -2);
    dump_cycle(0, 0);
    check_all();
    chk("t1_ie", a_ie, 3000); chk("t1_ql", a_ql, -2000);
    chk("t1_n", a_n, 1000); chk("t1_valid", a_v, 1);
    read_cycle();
    chk("t1_rd", a_v, 0);

    // Mixed chips, prompt negated.
    e = 1; p = 0; l = 1;
    samples(10, 1, 1);
    dump_cycle(0, 1);
    check_all();
    chk("t2_ie", a_ie, 10); chk("t2_ip", a_ip, -10); chk("t2_qp", a_qp, -10);
    chk("t2_ovr", a_o, 0);
    read_cycle();

    // Sample in the dump cycle belongs to the closing interval.
    e = 1; p = 1; l = 1;
    samples(4, 2, 0);
    is = 3'sd2; dump_cycle(1, 0);
    check_all();
    chk("t3_ip", a_ip, 10); chk("t3_n", a_n, 5);
    // Back-to-back dump without a read: empty interval, overrun.
    dump_cycle(0, 0);
    check_all();
    chk("t4_ip", a_ip, 0); chk("t4_n", a_n, 0); chk("t4_ovr", a_o, 1);

    // prn restart clears overrun and the partial interval.
    samples(7, 1, 1);
    prn = 1; tick(); prn = 0;
    check_all();
    chk("t5_valid", a_v, 0); chk("t5_hold", a_n, 0);
    samples(3, 1, 1);
    dump_cycle(0, 0);
    check_all();
    chk("t5_ip", a_ip, 3); chk("t5_ovr", a_o, 0);
    // Dump coincident with read: valid holds, no overrun.
    samples(2, 1, 1);
    dump_cycle(0, 1);
    check_all();
    chk("t6_valid", a_v, 1); chk("t6_ovr", a_o, 0);

    // Narrow accumulator overflow.
    rst = 1; tick(); rst = 0;
    e = 1; p = 1; l = 1;
    samples(50, 3, -4);
    dump_cycle(0, 0);
    check_all();
`ifdef EPL_SAT_EN
    chk("t7_ie8", b_ie, 127); chk("t7_qe8", b_qe, -128);
`else
    chk("t7_ie8", b_ie, -106); chk("t7_qe8", b_qe, 56);
`endif
    chk("t7_ie16", a_ie, 150);

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      en  = ($urandom_range(0, 3) != 0);
      is  = 3'($urandom_range(0, 7));
      qs  = 3'($urandom_range(0, 7));
      e   = 1'($urandom_range(0, 1));
      p   = 1'($urandom_range(0, 1));
      l   = 1'($urandom_range(0, 1));
      dmp = ($urandom_range(0, 19) == 0);
      rd  = ($urandom_range(0, 7) == 0);
      prn = ($urandom_range(0, 99) == 0);
      tick();
      check_all();
    end
    en = 0; dmp = 0; rd = 0; prn = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/epl_correlator.md
# epl_correlator

Early/prompt/late correlator and integrate-and-dump stage, directly downstream of the C/A code generator in each tracking channel. Each enabled sample is a carrier-wiped I/Q pair. The block multiplies it by the early, prompt and late code chips and accumulates the six products. On the code generator's dump pulse it latches the six sums and the sample count into readout registers for the tracking loop software, and raises a ready flag that the software read clears.

## Interface
- `SW`, 3: signed I/Q sample width.
- `AW`, 16: signed accumulator and dump register width; `AW` > `SW` + 1.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sample_enable`  in  1  qualifies `i_sample` and `q_sample` this cycle.
- `i_sample`, `q_sample`  in  SW  signed two's-complement baseband.
- `early`, `prompt`, `late`  in  1  code chips; 1 maps to +1, 0 maps to −1.
- `dump_enable`  in  1  one-cycle pulse that ends the integration interval.
- `prn_key_enable`  in  1  channel restart.
- `rd_strobe`  in  1  software has read the dump registers.
- `i_early`, `q_early`, `i_prompt`, `q_prompt`, `i_late`, `q_late`  out  AW  latched sums.
- `n_samples`  out  16  enabled samples in the latched interval.
- `acc_valid`  out  1  new dump is available.
- `overrun`  out  1  sticky; a dump overwrote unread data.

## Operation
- Product: for each chip c and sample s, the term is +s when c = 1 and −s when c = 0.
  - Sign-extend s to AW bits before negating, so −(−2^(SW−1)) is exact.
- Six running accumulators, `acc_XY` (X ∈ {i, q}, Y ∈ {early, prompt, late}):
  - When `sample_enable` = 1, `acc_XY` += term.
  - A 16-bit counter `cnt` increments by 1 at the same time.
- Let `next` be the accumulator value including this cycle's term, if any.
- Dump (`dump_enable` = 1):
  - Dump registers ← `next`.
  - `n_samples` ← `cnt` plus 1 if `sample_enable`, else `cnt`.
  - Accumulators and `cnt` ← 0. A sample in the dump cycle belongs to the closing interval.
- `acc_valid` is set by a dump and cleared by `rd_strobe`.
  - When a dump and `rd_strobe` occur in the same cycle, the dump wins and `acc_valid` stays 1.
- `overrun` ← 1 on a dump while `acc_valid` = 1 and `rd_strobe` = 0. The dump registers are still overwritten.
- `prn_key_enable` (lower priority than `rst`, higher than everything else):
  - Clears accumulators, `cnt`, `acc_valid` and `overrun`.
  - Any dump or sample in the same cycle is discarded.
  - Dump registers and `n_samples` hold their values.
- Arithmetic: accumulators wrap modulo 2^AW (see Configuration). `cnt` wraps at 2^16.

## Timing
- Reset values:
  - All six dump registers 0, `n_samples` 0, `acc_valid` 0, `overrun` 0.
  - Internal accumulators and `cnt` 0.
- Sample to accumulator: the term is added on the edge where `sample_enable` is high, so there is no input pipeline.
- Dump latency: the dump registers, `n_samples` and `acc_valid` update on the edge that samples `dump_enable`. They are visible the following cycle.
- `rd_strobe` clears `acc_valid` one edge later. `overrun` clears only through `rst` or `prn_key_enable`.
- Back-to-back dumps on consecutive cycles are legal. The second dump latches one sample or zero.
- `rst` in mid-interval discards the partial sums immediately.

## Configuration
- `EPL_SAT_EN` defined: each accumulator saturates, and an update never wraps.
  - Positive overflow clamps to 2^(AW−1)−1; negative overflow clamps to −2^(AW−1).
  - Dump takes the clamped value.
- `EPL_SAT_EN` undefined: plain two's-complement wrap. Saturation logic is absent.

## Test plan
- Reset, then 1000 samples with i=+3, q=−2, early=prompt=late=1, then a dump:
  - i_* = 3000, q_* = −2000, n_samples = 1000, acc_valid = 1 on the next cycle.
- Chips early=1, prompt=0, late=1 with i=+1, q=+1 for 10 samples:
  - After the dump, i_early = 10, i_prompt = −10, i_late = 10; the q values match the i values.
- Dump with `sample_enable` high in the same cycle, i=+2, after 4 earlier samples of +2:
  - i_prompt = 10, n_samples = 5; the next interval starts from 0.
- Two dumps without `rd_strobe`:
  - overrun = 1 and the second values are shown.
  - Dump coincident with `rd_strobe`: acc_valid stays 1 and overrun stays 0.
- `prn_key_enable` mid-interval after 7 samples, then 3 samples of +1 and a dump:
  - i_prompt = 3 and overrun = 0.
- AW=8, 50 samples of i=+3 with chip 1:
  - `EPL_SAT_EN` defined gives i_* = 127.
  - `EPL_SAT_EN` undefined gives i_* = 150 − 256 = −106.
